// File: rtl/cdb_pkg.sv
// Shared constants and bus type for the common data bus arbiter.
// Optional feature macro: CDB_ROUND_ROBIN_EN (see cdb_rr_picker).
package cdb_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  localparam logic [CDB_TAG_W-1:0] INVALID_TAG = '1;

  typedef struct packed {
    logic                  broadcast;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// One-hot winner selection for the CDB. CDB_ROUND_ROBIN_EN selects round robin
// starting after last_grant; otherwise fixed priority, lowest index wins.
module cdb_rr_picker
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int LG_W      = 3
) (
  input  logic [NUM_UNITS-1:0] request,
  input  logic [LG_W-1:0]      last_grant,
  output logic [NUM_UNITS-1:0] grant
);

`ifdef CDB_ROUND_ROBIN_EN
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_UNITS; off++) begin
      idx = (int'(last_grant) + off) % NUM_UNITS;
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  // Pointer is still kept by the parent but plays no part in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && request[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one functional unit per cycle and registers
// its tag/value onto the broadcast bus. Macro CDB_ROUND_ROBIN_EN enables round robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int DATA_W    = CDB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        in_request,
  input  logic [NUM_UNITS*TAG_W-1:0]  in_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] in_val,
  output logic [NUM_UNITS-1:0]        out_grant,
  output logic                        out_broadcast,
  output logic [TAG_W-1:0]            out_tag,
  output logic [DATA_W-1:0]           out_val
);

  localparam int LG_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [TAG_W-1:0] INV_TAG = {TAG_W{1'b1}};

  logic [NUM_UNITS-1:0] pick_p0;
  logic [LG_W-1:0]      last_grant;
  logic [TAG_W-1:0]     sel_tag_p0;
  logic [DATA_W-1:0]    sel_val_p0;
  logic [LG_W-1:0]      sel_idx_p0;
  logic                 gnt_any_p0;

  logic                 vld_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic [DATA_W-1:0]    val_p1;

  cdb_rr_picker #(
    .NUM_UNITS (NUM_UNITS),
    .LG_W      (LG_W)
  ) u_picker (
    .request    (in_request),
    .last_grant (last_grant),
    .grant      (pick_p0)
  );

  // Stage p0: grant is suppressed during reset so no unit sees an acceptance.
  assign out_grant  = rst ? '0 : pick_p0;
  assign gnt_any_p0 = |out_grant;

  always_comb begin
    sel_tag_p0 = '0;
    sel_val_p0 = '0;
    sel_idx_p0 = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (out_grant[i]) begin
        sel_tag_p0 = in_tag[i*TAG_W +: TAG_W];
        sel_val_p0 = in_val[i*DATA_W +: DATA_W];
        sel_idx_p0 = LG_W'(i);
      end
    end
  end

  // Stage p1: broadcast register; an invalid tag is consumed but not published.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      tag_p1     <= INV_TAG;
      val_p1     <= '0;
      last_grant <= LG_W'(NUM_UNITS - 1);
    end else if (gnt_any_p0) begin
      vld_p1     <= (sel_tag_p0 != INV_TAG);
      tag_p1     <= sel_tag_p0;
      val_p1     <= sel_val_p0;
      last_grant <= sel_idx_p0;
    end else begin
      vld_p1     <= 1'b0;
      tag_p1     <= INV_TAG;
    end
  end

  assign out_broadcast = vld_p1;
  assign out_tag       = tag_p1;
  assign out_val       = val_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: default 5-unit build plus an 8-unit, 64-bit build.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]   req;
  logic [24:0]  tags;
  logic [159:0] vals;
  logic [4:0]   gnt;
  logic         bc;
  logic [4:0]   otag;
  logic [31:0]  oval;

  logic [7:0]   req8;
  logic [39:0]  tags8;
  logic [511:0] vals8;
  logic [7:0]   gnt8;
  logic         bc8;
  logic [4:0]   otag8;
  logic [63:0]  oval8;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .in_request(req), .in_tag(tags), .in_val(vals),
    .out_grant(gnt), .out_broadcast(bc), .out_tag(otag), .out_val(oval)
  );

  cdb_arbiter #(.NUM_UNITS(8), .TAG_W(5), .DATA_W(64)) dut8 (
    .clk(clk), .rst(rst), .in_request(req8), .in_tag(tags8), .in_val(vals8),
    .out_grant(gnt8), .out_broadcast(bc8), .out_tag(otag8), .out_val(oval8)
  );

  task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tg, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_g;

  initial begin
    rst = 1'b1; req = '0; tags = '0; vals = '0;
    req8 = '0; tags8 = '0; vals8 = '0;

    // Reset with all requests pending: no grants, bus idle.
    req = 5'b11111;
    #1;
    chk("rst_grant", 64'(gnt), 64'h0);
    tick();
    chk("rst_bc", 64'(bc), 64'h0);
    chk("rst_tag", 64'(otag), 64'h1F);
    chk("rst_val", 64'(oval), 64'h0);
    chk("rst_lg", 64'(dut.last_grant), 64'd4);
    chk("rst_lg8", 64'(dut8.last_grant), 64'd7);

    // Single request from unit 2.
    rst = 1'b0; req = 5'b00100;
    tags[2*5 +: 5] = 5'd7; vals[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("single_grant", 64'(gnt), 64'b00100);
    tick();
    chk("single_bc", 64'(bc), 64'h1);
    chk("single_tag", 64'(otag), 64'd7);
    chk("single_val", 64'(oval), 64'hDEAD_BEEF);
    req = '0;
    #1;
    chk("idle_grant", 64'(gnt), 64'h0);
    tick();
    chk("idle_bc", 64'(bc), 64'h0);
    chk("idle_tag", 64'(otag), 64'h1F);
    chk("idle_hold_val", 64'(oval), 64'hDEAD_BEEF);

    // All five units request continuously after a fresh reset.
    for (int i = 0; i < 5; i++) begin
      tags[i*5 +: 5]  = 5'(i + 1);
      vals[i*32 +: 32] = 32'h100 + 32'(i);
    end
    rst = 1'b1; req = 5'b11111;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
`ifdef CDB_ROUND_ROBIN_EN
      exp_g = 5'b00001 << (c % 5);
`else
      exp_g = 5'b00001;
`endif
      #1;
      chk($sformatf("all_grant%0d", c), 64'(gnt), 64'(exp_g));
      tick();
      chk($sformatf("all_bc%0d", c), 64'(bc), 64'h1);
`ifdef CDB_ROUND_ROBIN_EN
      chk($sformatf("all_tag%0d", c), 64'(otag), 64'((c % 5) + 1));
`else
      chk($sformatf("all_tag%0d", c), 64'(otag), 64'd1);
`endif
    end

    // Units 1 and 3 with a one-cycle reset in the middle (last_grant is 0 here).
    req = 5'b01010;
    #1;
    chk("mid_grant_pre", 64'(gnt), 64'b00010);
    tick();
    chk("mid_tag_pre", 64'(otag), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(gnt), 64'h0);
    tick();
    chk("mid_rst_bc", 64'(bc), 64'h0);
    chk("mid_rst_val", 64'(oval), 64'h0);
    rst = 1'b0;
    #1;
    chk("mid_post_grant1", 64'(gnt), 64'b00010);
    tick();
    chk("mid_post_tag1", 64'(otag), 64'd2);
    req = 5'b01000;
    #1;
    chk("mid_post_grant3", 64'(gnt), 64'b01000);
    tick();
    chk("mid_post_tag3", 64'(otag), 64'd4);
    chk("mid_post_val3", 64'(oval), 64'h103);

    // Unit 0 then unit 4 with the invalid tag: consumed, not published.
    req = 5'b00001;
    #1;
    chk("inv_pre_grant", 64'(gnt), 64'b00001);
    tick();
    chk("inv_pre_lg", 64'(dut.last_grant), 64'd0);
    req = 5'b10000; tags[4*5 +: 5] = 5'h1F;
    #1;
    chk("inv_grant", 64'(gnt), 64'b10000);
    tick();
    chk("inv_bc", 64'(bc), 64'h0);
    chk("inv_lg", 64'(dut.last_grant), 64'd4);

    // A request abandoned without a grant leaves no trace.
    req = 5'b00011;
    #1;
    chk("drop_grant", 64'(gnt), 64'b00001);
    tick();
    req = '0;
    tick();
    chk("drop_bc", 64'(bc), 64'h0);
    chk("drop_lg", 64'(dut.last_grant), 64'd0);

    // Wide build: unit 7 alone, then units 0 and 7 (wraps from 7 to 0).
    for (int i = 0; i < 8; i++) begin
      tags8[i*5 +: 5]  = 5'(i + 8);
      vals8[i*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
    end
    vals8[7*64 +: 64] = 64'h0123_4567_89AB_CDEF;
    req8 = 8'h80;
    #1;
    chk("w_grant7", 64'(gnt8), 64'h80);
    tick();
    chk("w_bc7", 64'(bc8), 64'h1);
    chk("w_tag7", 64'(otag8), 64'd15);
    chk("w_val7", oval8, 64'h0123_4567_89AB_CDEF);
    req8 = 8'h81;
    #1;
    chk("w_wrap_grant0", 64'(gnt8), 64'h01);
    tick();
    chk("w_val0", oval8, 64'hA5A5_0000_0000_0000);
    req8 = 8'h80;
    #1;
    chk("w_grant7b", 64'(gnt8), 64'h80);
    tick();
    chk("w_lg7", 64'(dut8.last_grant), 64'd7);
    req8 = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 5, number of requesting functional units (2..16).
REQ-002 SHALL have parameter TAG_W, default 5, tag width.
REQ-003 SHALL have parameter DATA_W, default 32, result value width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_request  input  NUM_UNITS  per-unit broadcast request.
REQ-007 SHALL have port in_tag  input  NUM_UNITS*TAG_W  per-unit tag; unit i occupies bits [i*TAG_W +: TAG_W].
REQ-008 SHALL have port in_val  input  NUM_UNITS*DATA_W  per-unit value; unit i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port out_grant  output  NUM_UNITS  one-hot, combinational; the unit whose request is accepted this cycle.
REQ-010 SHALL have port out_broadcast  output  1  registered; broadcast valid.
REQ-011 SHALL have port out_tag  output  TAG_W  registered; broadcast tag.
REQ-012 SHALL have port out_val  output  DATA_W  registered; broadcast value.

Function
REQ-013 Handshake: a unit raises in_request[i] with in_tag/in_val stable and holds them until it samples out_grant[i]=1 at a rising edge.
REQ-014 out_grant SHALL be zero or one-hot; at most one grant per cycle; never granted to a unit without in_request.
REQ-015 On the edge where out_grant[i]=1, out_broadcast<=1, out_tag<=tag i, out_val<=value i; latency request-to-broadcast is exactly 1 cycle when uncontended.
REQ-016 When no request is present, out_broadcast<=0, out_tag<=INVALID_TAG (all ones), out_val holds its previous value.
REQ-017 Throughput: one broadcast per cycle; back-to-back grants to different or the same unit are allowed.
REQ-018 A unit presenting tag INVALID_TAG with in_request=1 SHALL still be arbitrated and granted, but the broadcast carries out_broadcast=0 (consumed, not published).
REQ-019 Arbitration: a registered pointer last_grant (log2 NUM_UNITS bits) records the most recent granted index; updated only on a grant.
REQ-020 Simultaneous requests: the losers keep requesting; no request is dropped; there is no bound on wait time under fixed priority, and a bound of NUM_UNITS-1 cycles under round robin.
REQ-021 A request deasserted without a grant SHALL be ignored without side effects.

Reset
REQ-022 While rst=1 at an edge: out_broadcast<=0, out_tag<=INVALID_TAG, out_val<=0, last_grant<=NUM_UNITS-1.
REQ-023 While rst=1, out_grant SHALL be all zero regardless of in_request; a request pending across reset is granted normally after reset.

Configuration
REQ-024 Macro CDB_ROUND_ROBIN_EN defined: the winner is the first requester scanning upward from last_grant+1, wrapping modulo NUM_UNITS.
REQ-025 Macro CDB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; last_grant is still maintained but does not influence selection.

Structure
REQ-026 Shared package cdb_pkg SHALL hold the CDB_TAG_W and CDB_DATA_W default constants, INVALID_TAG, and the cdb_bus_t struct (broadcast, tag, val).
REQ-027 The selection logic SHALL be a sub-module cdb_rr_picker (inputs: request vector, last_grant; output: one-hot grant); the output register stays in cdb_arbiter.

Verification
REQ-028 Single request: unit 2 requests, tag 5'd7, val 32'hDEAD_BEEF -> out_grant=5'b00100 in that cycle; the next cycle gives broadcast=1, tag=7, val=DEAD_BEEF; the following idle cycle gives broadcast=0, tag=5'h1F.
REQ-029 All 5 units request continuously with round robin enabled and last_grant=4 after reset -> grants 0,1,2,3,4,0 on consecutive cycles, and broadcast is high for every cycle after the first.
REQ-030 Same stimulus with CDB_ROUND_ROBIN_EN undefined -> unit 0 is granted every cycle; units 1-4 are never granted while unit 0 holds its request.
REQ-031 Units 1 and 3 request; rst is asserted for one cycle in the middle of the sequence -> during reset, grant=0 and broadcast=0; after reset, unit 1 is granted first, then unit 3.
REQ-032 Unit 4 requests with tag 5'h1F -> out_grant[4]=1, and the next cycle gives broadcast=0 with last_grant=4.
REQ-033 NUM_UNITS=8, DATA_W=64 build: unit 7 requests alone -> correct slice is broadcast after 1 cycle; wrap-around to unit 0 works under round robin.
